memwb_pipe: RTL and testbench
=============================

// Module: memwb_pipe
// PURPOSE
//  Pipelined memory/writeback stage. Keeps up to DEPTH operations in flight and retires register writes strictly in order.
//  Sits between execute (i_submit/o_ready handshake) and the register file (o_reg_ie/o_reg_data).
//  Drives a split-transaction bus: one request phase (req/ack) and an in-order response phase (rvalid).
//  Successor of the single-outstanding memwb stage: loads now overlap instead of stalling execute per access.
// PARAMETERS
//  RW     16  data/address width, bits
//  REGNO  8   register-file write-enable one-hot width
//  DEPTH  4   completion-queue entries; power of two, >=2
// PORTS
//  i_clk         in   1      clock, all state on rising edge
//  i_rst_n       in   1      asynchronous active-low reset
//  i_submit      in   1      execute presents an op; accepted when i_submit & o_ready
//  o_ready       out  1      stage can accept an op this cycle
//  i_data        in   RW     ALU result (non-mem) or store data
//  i_addr        in   RW     memory address
//  i_reg_ie      in   REGNO  destination one-hot; 0 = no writeback
//  i_mem_access  in   1      op accesses memory
//  i_mem_we      in   1      store when 1, load when 0 (valid with i_mem_access)
//  o_reg_ie      out  REGNO  register write enable for the retiring op
//  o_reg_data    out  RW     register write data
//  o_mem_req     out  1      bus request valid, held until i_mem_ack
//  o_mem_addr    out  RW     registered request address
//  o_mem_data    out  RW     registered store data
//  o_mem_we      out  1      registered write flag
//  i_mem_ack     in   1      bus accepted the current request this cycle
//  i_mem_rvalid  in   1      in-order response for the oldest issued request
//  i_mem_data    in   RW     load data, valid with i_mem_rvalid
//  o_busy        out  1      queue non-empty or request pending
// BEHAVIOUR
//  Reset (async, i_rst_n=0): queue empty, pointers 0, o_mem_req=0, o_mem_addr/data/we=0, o_reg_ie=0, o_busy=0.
//   Reset mid-transaction abandons all in-flight ops; responses arriving after reset are ignored.
//  Queue: DEPTH entries {reg_ie, mem_access, we, data}; rd/wr pointers carry a wrap bit (log2(DEPTH)+1 bits).
//   full = equal index and opposite wrap bit; empty = equal pointers incl. wrap bit.
//  o_ready = ~full & (~o_mem_req | i_mem_ack). Combinational; no enqueue-when-full pass-through.
//  Accept (cycle N): entry written at wr_ptr.
//   If i_mem_access: request register loads addr/data/we; o_mem_req=1 from N+1.
//  Request phase: o_mem_req stays 1 with stable addr/data/we until the cycle i_mem_ack=1.
//   Accept in the ack cycle reloads the request register; otherwise o_mem_req drops at the next edge.
//  Retire: head entry only, at most one per cycle.
//   Non-mem head retires in the first cycle it is head; earliest is N+1 for an op accepted at N into an empty queue.
//   Mem head retires in the cycle i_mem_rvalid=1 (earliest the cycle after its ack).
//   Store responses retire with o_reg_ie=0.
//  Writeback (combinational in the retire cycle): o_reg_ie = head.reg_ie, else 0.
//   o_reg_data = i_mem_data for a load, head.data otherwise.
//  i_mem_rvalid with a non-mem head, or with an empty queue: ignored, no state change.
//   The bus must not respond to unacked requests.
//  Simultaneous accept + retire: both occur; occupancy unchanged; wrap-around is handled by pointer arithmetic.
//  Outside a retire cycle o_reg_ie=0 and o_reg_data = head.data (don't-care).
// CONFIGURATION
//  MEMWB_BYTE_EN defined: adds the following ports.
//   i_mem_byte  in  1  byte access
//   i_mem_sext  in  1  sign-extend loaded byte
//   o_mem_sel   out 2  lane select: 2'b01 = even addr, 2'b10 = odd addr, 2'b11 = word access
//  Byte loads take lane i_mem_data[7:0] for addr[0]=0, [15:8] for addr[0]=1, then zero- or sign-extend to RW.
//  Byte stores replicate i_data[7:0] onto both lanes. Queue entries also hold byte, sext and addr[0].
//  MEMWB_BYTE_EN undefined: those ports are absent; all accesses are full-word.
// TESTING
//  1) Non-mem op, reg_ie=8'h04, data=16'h1234, empty queue -> o_reg_ie=8'h04, o_reg_data=16'h1234 exactly one cycle later.
//  2) Loads from 0x10, 0x12, 0x14 on consecutive cycles, ack same cycle, rvalid 2 cycles later with 0xAAAA/0xBBBB/0xCCCC
//     -> three in-order writebacks with those values, o_ready never low.
//  3) DEPTH=4: five back-to-back loads, rvalid withheld -> o_ready=0 after the 4th; first rvalid -> o_ready=1 next cycle, pointers wrap.
//  4) Load (no response yet) then non-mem op reg_ie=8'h02 -> non-mem writeback waits until the load retires (in-order).
//  5) i_rst_n low while o_mem_req=1 with 2 entries queued -> o_mem_req=0 and o_busy=0 immediately;
//     a later rvalid causes no o_reg_ie.
//  6) MEMWB_BYTE_EN: byte load, sext=1, addr=0x0001, i_mem_data=16'h80FF -> o_mem_sel=2'b10, o_reg_data=16'hFF80.

Source files
------------

// File: rtl/memwb_pipe_if.sv
// memwb_pipe_if: execute handshake, register-file writeback and split-transaction
// bus signals of the memwb_pipe stage. The byte-lane extension signals exist only
// when MEMWB_BYTE_EN is defined.
interface memwb_pipe_if #(
    parameter int RW    = 16,
    parameter int REGNO = 8
);
    // execute side
    logic             i_submit;
    logic             o_ready;
    logic [RW-1:0]    i_data;
    logic [RW-1:0]    i_addr;
    logic [REGNO-1:0] i_reg_ie;
    logic             i_mem_access;
    logic             i_mem_we;
    // register-file side
    logic [REGNO-1:0] o_reg_ie;
    logic [RW-1:0]    o_reg_data;
    // bus side
    logic             o_mem_req;
    logic [RW-1:0]    o_mem_addr;
    logic [RW-1:0]    o_mem_data;
    logic             o_mem_we;
    logic             i_mem_ack;
    logic             i_mem_rvalid;
    logic [RW-1:0]    i_mem_data;
    logic             o_busy;
`ifdef MEMWB_BYTE_EN
    logic             i_mem_byte;
    logic             i_mem_sext;
    logic [1:0]       o_mem_sel;
`endif

    // stage view
    modport slave (
        input  i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we,
        input  i_mem_ack, i_mem_rvalid, i_mem_data,
`ifdef MEMWB_BYTE_EN
        input  i_mem_byte, i_mem_sext,
        output o_mem_sel,
`endif
        output o_ready, o_reg_ie, o_reg_data,
        output o_mem_req, o_mem_addr, o_mem_data, o_mem_we, o_busy
    );

    // environment view (execute + bus + register file)
    modport master (
        output i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we,
        output i_mem_ack, i_mem_rvalid, i_mem_data,
`ifdef MEMWB_BYTE_EN
        output i_mem_byte, i_mem_sext,
        input  o_mem_sel,
`endif
        input  o_ready, o_reg_ie, o_reg_data,
        input  o_mem_req, o_mem_addr, o_mem_data, o_mem_we, o_busy
    );
endinterface

// File: rtl/memwb_pipe.sv
// memwb_pipe: pipelined memory/writeback stage. Up to DEPTH ops are held in an
// in-order completion queue; memory ops issue one request at a time on a
// req/ack bus and retire when their in-order rvalid response arrives.
// Optional byte-lane support is enabled by defining MEMWB_BYTE_EN (assumes RW=16).
module memwb_pipe #(
    parameter int RW    = 16,
    parameter int REGNO = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    memwb_pipe_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // completion queue storage
    logic [REGNO-1:0] q_reg_ie_r [DEPTH];
    logic             q_mem_r    [DEPTH];
    logic             q_we_r     [DEPTH];
    logic [RW-1:0]    q_data_r   [DEPTH];
`ifdef MEMWB_BYTE_EN
    logic             q_byte_r   [DEPTH];
    logic             q_sext_r   [DEPTH];
    logic             q_a0_r     [DEPTH];
    logic [1:0]       req_sel_r;
    logic [7:0]       lane_s;
`endif

    // pointers carry a wrap bit above the index
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;

    // request register
    logic             req_r;
    logic [RW-1:0]    req_addr_r;
    logic [RW-1:0]    req_data_r;
    logic             req_we_r;

    logic [IW-1:0]    wr_idx_s;
    logic [IW-1:0]    rd_idx_s;
    logic             empty_s;
    logic             full_s;
    logic             ready_s;
    logic             accept_s;
    logic             head_mem_s;
    logic             head_load_s;
    logic             head_store_s;
    logic             retire_s;
    logic [RW-1:0]    st_data_s;
    logic [RW-1:0]    load_data_s;
    logic [REGNO-1:0] reg_ie_s;
    logic [RW-1:0]    reg_data_s;

    // occupancy, handshake and retire decisions
    always_comb begin
        wr_idx_s     = wr_ptr_r[IW-1:0];
        rd_idx_s     = rd_ptr_r[IW-1:0];
        empty_s      = (wr_ptr_r == rd_ptr_r);
        full_s       = (wr_idx_s == rd_idx_s) && (wr_ptr_r[IW] != rd_ptr_r[IW]);
        ready_s      = ~full_s & (~req_r | bus.i_mem_ack);
        accept_s     = bus.i_submit & ready_s;
        head_mem_s   = q_mem_r[rd_idx_s];
        head_load_s  = head_mem_s & ~q_we_r[rd_idx_s];
        head_store_s = head_mem_s & q_we_r[rd_idx_s];
        // a memory head waits for its response; rvalid on a non-mem head is ignored
        retire_s     = ~empty_s & (~head_mem_s | bus.i_mem_rvalid);
    end

    // store data formatting and load data extraction
    always_comb begin
        st_data_s   = bus.i_data;
        load_data_s = bus.i_mem_data;
`ifdef MEMWB_BYTE_EN
        lane_s = 8'h00;
        if (bus.i_mem_byte) begin
            st_data_s = {bus.i_data[7:0], bus.i_data[7:0]};
        end else begin
            st_data_s = bus.i_data;
        end
        if (q_a0_r[rd_idx_s]) begin
            lane_s = bus.i_mem_data[15:8];
        end else begin
            lane_s = bus.i_mem_data[7:0];
        end
        if (q_byte_r[rd_idx_s]) begin
            load_data_s = {{(RW-8){q_sext_r[rd_idx_s] & lane_s[7]}}, lane_s};
        end else begin
            load_data_s = bus.i_mem_data;
        end
`endif
    end

    // writeback for the retiring head; stores never write the register file
    always_comb begin
        reg_ie_s   = {REGNO{1'b0}};
        reg_data_s = q_data_r[rd_idx_s];
        if (retire_s && !head_store_s) begin
            reg_ie_s = q_reg_ie_r[rd_idx_s];
        end else begin
            reg_ie_s = {REGNO{1'b0}};
        end
        if (retire_s && head_load_s) begin
            reg_data_s = load_data_s;
        end else begin
            reg_data_s = q_data_r[rd_idx_s];
        end
    end

    // queue entry write on accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_reg_ie_r[i] <= {REGNO{1'b0}};
                q_mem_r[i]    <= 1'b0;
                q_we_r[i]     <= 1'b0;
                q_data_r[i]   <= {RW{1'b0}};
`ifdef MEMWB_BYTE_EN
                q_byte_r[i]   <= 1'b0;
                q_sext_r[i]   <= 1'b0;
                q_a0_r[i]     <= 1'b0;
`endif
            end
        end else if (accept_s) begin
            q_reg_ie_r[wr_idx_s] <= bus.i_reg_ie;
            q_mem_r[wr_idx_s]    <= bus.i_mem_access;
            q_we_r[wr_idx_s]     <= bus.i_mem_we;
            q_data_r[wr_idx_s]   <= bus.i_data;
`ifdef MEMWB_BYTE_EN
            q_byte_r[wr_idx_s]   <= bus.i_mem_byte;
            q_sext_r[wr_idx_s]   <= bus.i_mem_sext;
            q_a0_r[wr_idx_s]     <= bus.i_addr[0];
`endif
        end
    end

    // read/write pointer advance; wrap is handled by the extra pointer bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // request register: loads on a memory accept, held until acked
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_r      <= 1'b0;
            req_addr_r <= {RW{1'b0}};
            req_data_r <= {RW{1'b0}};
            req_we_r   <= 1'b0;
`ifdef MEMWB_BYTE_EN
            req_sel_r  <= 2'b00;
`endif
        end else if (accept_s && bus.i_mem_access) begin
            req_r      <= 1'b1;
            req_addr_r <= bus.i_addr;
            req_data_r <= st_data_s;
            req_we_r   <= bus.i_mem_we;
`ifdef MEMWB_BYTE_EN
            if (bus.i_mem_byte) begin
                req_sel_r <= bus.i_addr[0] ? 2'b10 : 2'b01;
            end else begin
                req_sel_r <= 2'b11;
            end
`endif
        end else if (bus.i_mem_ack) begin
            req_r <= 1'b0;
        end
    end

    assign bus.o_ready    = ready_s;
    assign bus.o_reg_ie   = reg_ie_s;
    assign bus.o_reg_data = reg_data_s;
    assign bus.o_mem_req  = req_r;
    assign bus.o_mem_addr = req_addr_r;
    assign bus.o_mem_data = req_data_r;
    assign bus.o_mem_we   = req_we_r;
    assign bus.o_busy     = ~empty_s | req_r;
`ifdef MEMWB_BYTE_EN
    assign bus.o_mem_sel  = req_sel_r;
`endif
endmodule

// File: tb/tb_memwb_pipe.sv
// tb_memwb_pipe: directed, table-driven bench for memwb_pipe (DEPTH=4).
// Each table row drives one cycle of inputs and lists the outputs expected
// in that same cycle; multi-cycle corners are hand-written sequences.
module tb_memwb_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    memwb_pipe_if #(.RW(16), .REGNO(8)) bus ();
    memwb_pipe #(.RW(16), .REGNO(8), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sub;
        logic        ma;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [7:0]  rie;
        logic        ack;
        logic        rv;
        logic [15:0] rdata;
        logic        e_ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_mdata;
        logic        e_mwe;
        logic        e_busy;
        logic [7:0]  e_rie;
        logic [15:0] e_rdata;
    } vec_t;

    function automatic vec_t mkv(
        input logic sub, input logic ma, input logic we, input logic [15:0] addr,
        input logic [15:0] data, input logic [7:0] rie, input logic ack, input logic rv,
        input logic [15:0] rdata, input logic e_ready, input logic e_req,
        input logic [15:0] e_addr, input logic [15:0] e_mdata, input logic e_mwe,
        input logic e_busy, input logic [7:0] e_rie, input logic [15:0] e_rdata);
        vec_t v;
        v = {sub, ma, we, addr, data, rie, ack, rv, rdata,
             e_ready, e_req, e_addr, e_mdata, e_mwe, e_busy, e_rie, e_rdata};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic sub, input logic ma, input logic we, input logic [15:0] addr,
                         input logic [15:0] data, input logic [7:0] rie, input logic ack,
                         input logic rv, input logic [15:0] rdata);
        bus.i_submit     = sub;
        bus.i_mem_access = ma;
        bus.i_mem_we     = we;
        bus.i_addr       = addr;
        bus.i_data       = data;
        bus.i_reg_ie     = rie;
        bus.i_mem_ack    = ack;
        bus.i_mem_rvalid = rv;
        bus.i_mem_data   = rdata;
`ifdef MEMWB_BYTE_EN
        bus.i_mem_byte   = 1'b0;
        bus.i_mem_sext   = 1'b0;
`endif
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [25];

    initial begin
        // T1 non-mem op into empty queue
        vecs[0]  = mkv(1,0,0,16'h0000,16'h1234,8'h04,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        vecs[1]  = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 1,8'h04,16'h1234);
        vecs[2]  = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        // T2 three overlapped loads, ack on first request cycle, rvalid two cycles after ack
        vecs[3]  = mkv(1,1,0,16'h0010,16'h0000,8'h01,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        vecs[4]  = mkv(1,1,0,16'h0012,16'h0000,8'h02,1,0,16'h0000, 1,1,16'h0010,16'h0000,0, 1,8'h00,16'h0000);
        vecs[5]  = mkv(1,1,0,16'h0014,16'h0000,8'h04,1,0,16'h0000, 1,1,16'h0012,16'h0000,0, 1,8'h00,16'h0000);
        vecs[6]  = mkv(0,0,0,16'h0000,16'h0000,8'h00,1,1,16'hAAAA, 1,1,16'h0014,16'h0000,0, 1,8'h01,16'hAAAA);
        vecs[7]  = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,1,16'hBBBB, 1,0,16'h0000,16'h0000,0, 1,8'h02,16'hBBBB);
        vecs[8]  = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,1,16'hCCCC, 1,0,16'h0000,16'h0000,0, 1,8'h04,16'hCCCC);
        vecs[9]  = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        // T4 non-mem op behind an outstanding load retires after it
        vecs[10] = mkv(1,1,0,16'h0020,16'h0000,8'h08,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        vecs[11] = mkv(1,0,0,16'h0000,16'h5555,8'h02,1,0,16'h0000, 1,1,16'h0020,16'h0000,0, 1,8'h00,16'h0000);
        vecs[12] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 1,8'h00,16'h0000);
        vecs[13] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 1,8'h00,16'h0000);
        vecs[14] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,1,16'h7777, 1,0,16'h0000,16'h0000,0, 1,8'h08,16'h7777);
        vecs[15] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 1,8'h02,16'h5555);
        vecs[16] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        // stray rvalid with an empty queue
        vecs[17] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,1,16'h9999, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        // store: registered request fields, retires without register write
        vecs[18] = mkv(1,1,1,16'h0030,16'hBEEF,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        vecs[19] = mkv(0,0,0,16'h0000,16'h0000,8'h00,1,0,16'h0000, 1,1,16'h0030,16'hBEEF,1, 1,8'h00,16'h0000);
        vecs[20] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,1,16'h0000, 1,0,16'h0000,16'h0000,0, 1,8'h00,16'h0000);
        vecs[21] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        // rvalid alongside a non-mem head: op retires with its own data
        vecs[22] = mkv(1,0,0,16'h0000,16'h0ABC,8'h01,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);
        vecs[23] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,1,16'h1111, 1,0,16'h0000,16'h0000,0, 1,8'h01,16'h0ABC);
        vecs[24] = mkv(0,0,0,16'h0000,16'h0000,8'h00,0,0,16'h0000, 1,0,16'h0000,16'h0000,0, 0,8'h00,16'h0000);

        idle();
        #12;
        // reset state
        chk("rst_req",   {31'd0, bus.o_mem_req}, 32'd0);
        chk("rst_busy",  {31'd0, bus.o_busy},    32'd0);
        chk("rst_reg_ie",{24'd0, bus.o_reg_ie},  32'd0);
        chk("rst_addr",  {16'd0, bus.o_mem_addr},32'd0);
        chk("rst_mdata", {16'd0, bus.o_mem_data},32'd0);
        chk("rst_we",    {31'd0, bus.o_mem_we},  32'd0);
        chk("rst_ready", {31'd0, bus.o_ready},   32'd1);
        next_cycle();
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].sub, vecs[i].ma, vecs[i].we, vecs[i].addr, vecs[i].data,
                  vecs[i].rie, vecs[i].ack, vecs[i].rv, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), {31'd0, bus.o_ready},  {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_req", i),   {31'd0, bus.o_mem_req},{31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_busy", i),  {31'd0, bus.o_busy},   {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_reg_ie", i),{24'd0, bus.o_reg_ie}, {24'd0, vecs[i].e_rie});
            if (vecs[i].e_rie != 8'h00) begin
                chk($sformatf("v%0d_reg_data", i), {16'd0, bus.o_reg_data}, {16'd0, vecs[i].e_rdata});
            end
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_maddr", i), {16'd0, bus.o_mem_addr}, {16'd0, vecs[i].e_addr});
                chk($sformatf("v%0d_mdata", i), {16'd0, bus.o_mem_data}, {16'd0, vecs[i].e_mdata});
                chk($sformatf("v%0d_mwe", i),   {31'd0, bus.o_mem_we},   {31'd0, vecs[i].e_mwe});
            end
            next_cycle();
        end

        // T3: five back-to-back loads with no responses fill the queue, then wrap
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'h0000, 8'h01 << i,
                  (i > 0) ? 1'b1 : 1'b0, 1'b0, 16'h0000);
            @(negedge clk);
            chk($sformatf("fill%0d_ready", i), {31'd0, bus.o_ready}, (i < 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0048, 16'h0000, 8'h10, 1'b0, 1'b1, 16'h1111);
        @(negedge clk);
        chk("full_rv_ready", {31'd0, bus.o_ready},  32'd0);
        chk("full_rv_reg_ie",{24'd0, bus.o_reg_ie}, 32'h01);
        chk("full_rv_data",  {16'd0, bus.o_reg_data}, 32'h1111);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 16'h0048, 16'h0000, 8'h10, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("after_rv_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("after_rv_reg_ie",{24'd0, bus.o_reg_ie}, 32'h00);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h2222);
        @(negedge clk);
        chk("wrap_req",    {31'd0, bus.o_mem_req}, 32'd1);
        chk("wrap_addr",   {16'd0, bus.o_mem_addr}, 32'h0048);
        chk("wrap_ready",  {31'd0, bus.o_ready}, 32'd0);
        chk("wrap_reg_ie1",{24'd0, bus.o_reg_ie}, 32'h02);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h3333 + 16'(i) * 16'h1111);
            @(negedge clk);
            chk($sformatf("drain%0d_reg_ie", i), {24'd0, bus.o_reg_ie}, 32'h04 << i);
            chk($sformatf("drain%0d_data", i), {16'd0, bus.o_reg_data}, 32'h3333 + 32'(i) * 32'h1111);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("drain_busy", {31'd0, bus.o_busy}, 32'd0);
        next_cycle();

        // T5: reset with a pending request and two queued loads
        drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0000, 8'h01, 1'b0, 1'b0, 16'h0000);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 16'h0062, 16'h0000, 8'h02, 1'b1, 1'b0, 16'h0000);
        next_cycle();
        idle();
        #1;
        chk("pre_rst_req", {31'd0, bus.o_mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",  {31'd0, bus.o_mem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("mid_rst_addr", {16'd0, bus.o_mem_addr}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hDEAD);
        @(negedge clk);
        chk("late_rv_reg_ie", {24'd0, bus.o_reg_ie}, 32'd0);
        chk("late_rv_busy",   {31'd0, bus.o_busy}, 32'd0);
        next_cycle();
        idle();

`ifdef MEMWB_BYTE_EN
        // T6: signed byte load from odd address
        drive(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000, 8'h01, 1'b0, 1'b0, 16'h0000);
        bus.i_mem_byte = 1'b1;
        bus.i_mem_sext = 1'b1;
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("byte_sel", {30'd0, bus.o_mem_sel}, 32'h2);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h80FF);
        @(negedge clk);
        chk("byte_reg_ie", {24'd0, bus.o_reg_ie}, 32'h01);
        chk("byte_data",   {16'd0, bus.o_reg_data}, 32'hFF80);
        next_cycle();
        // byte store to even address replicates the low byte
        drive(1'b1, 1'b1, 1'b1, 16'h0002, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000);
        bus.i_mem_byte = 1'b1;
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("bst_sel",  {30'd0, bus.o_mem_sel}, 32'h1);
        chk("bst_data", {16'd0, bus.o_mem_data}, 32'h3434);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000);
        next_cycle();
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
